// File: rtl/instr_issuer.sv
// Instruction issuer: fetches words from a synchronous program memory and
// hands them to a processor one instruction at a time. Two-word mvi
// instructions deliver their immediate in the cycle after the opcode word.
// The issuer waits for Done with a bounded timeout and stops on a halt
// opcode or on a timeout.
module instr_issuer #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned PROG_LEN = 16,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Go,
  input  logic              Done,
  input  logic [15:0]       MemQ,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       DIN,
  output logic              Run,
  output logic              Busy,
  output logic              Halted,
  output logic              Err,
  output logic [7:0]        InstrCount
);

  // The counter only has to hold 0..TIMEOUT-1. The last value is the final WAIT cycle.
  localparam int unsigned       CntW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CntW-1:0]   CntLast = CntW'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PcLast  = ADDR_W'(PROG_LEN - 1);
  localparam logic [2:0]        OpMvi   = 3'b001;
  localparam logic [2:0]        OpHalt  = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StLatch,
    StExec,
    StImm,
    StWait,
    StHalt
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_inc;
  logic [CntW-1:0]   cnt_q;
  logic [15:0]       din_q;
  logic              run_q;
  logic              err_q;
  logic [7:0]        count_q;

  // Next program address, wrapping from the last valid word back to 0
  always_comb begin
    pc_inc = (pc_q == PcLast) ? '0 : pc_q + ADDR_W'(1);
  end

  // LATCH prefetches the following word so that an mvi immediate is ready in EXEC
  always_comb begin
    MemAddr = (state_q == StLatch) ? pc_inc : pc_q;
  end

  // Status decode and output drive
  always_comb begin
    Busy       = (state_q != StIdle) && (state_q != StHalt);
    Halted     = (state_q == StHalt);
    DIN        = din_q;
    Run        = run_q;
    Err        = err_q;
    InstrCount = count_q;
  end

  // Issue FSM together with its registered outputs
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cnt_q   <= '0;
      din_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (Go) state_q <= StRd;
        end
        StRd: begin
          state_q <= StLatch;
        end
        StLatch: begin
          // A halt word is never issued: DIN, Run and pc keep their values
          if (MemQ[15:13] == OpHalt) begin
            state_q <= StHalt;
          end else begin
            din_q   <= MemQ;
            run_q   <= 1'b1;
            pc_q    <= pc_inc;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (din_q[15:13] == OpMvi) begin
            din_q   <= MemQ;
            pc_q    <= pc_inc;
            state_q <= StImm;
          end else begin
            cnt_q   <= '0;
            state_q <= StWait;
          end
        end
        StImm: begin
          cnt_q   <= '0;
          state_q <= StWait;
        end
        StWait: begin
          // Done on the final allowed cycle still counts as a completion
          if (Done) begin
            run_q   <= 1'b0;
            count_q <= count_q + 8'd1;
            state_q <= Go ? StRd : StIdle;
          end else if (cnt_q == CntLast) begin
            err_q   <= 1'b1;
            run_q   <= 1'b0;
            state_q <= StHalt;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StHalt: begin
          state_q <= StHalt;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
